// File: rtl/h_xor_accum.sv
// Streaming XOR checksum: folds a frame of words into one WIDTH-bit sum,
// then holds the sum, its parity and the saturating word count until consumed.
module h_xor_accum #(
    parameter int unsigned           WIDTH = 16,
    parameter int unsigned           CNT_W = 8,
    parameter logic [WIDTH-1:0]      SEED  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_acc, w_acc_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]   r_sum, w_sum_nxt;
    logic [CNT_W-1:0]   r_count, w_count_nxt;
    logic               r_parity, w_parity_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_ready, w_ready_nxt;
    logic               w_xfer;

    // in_ready is a register, so out_ready never reaches it combinationally
    assign w_xfer = in_valid & r_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_acc    <= SEED;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_count  <= '0;
            r_parity <= 1'b0;
            r_valid  <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sum    <= w_sum_nxt;
            r_count  <= w_count_nxt;
            r_parity <= w_parity_nxt;
            r_valid  <= w_valid_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_sum_nxt    = r_sum;
        w_count_nxt  = r_count;
        w_parity_nxt = r_parity;

        if (clr) begin
            w_state_nxt  = IDLE;
            w_acc_nxt    = SEED;
            w_cnt_nxt    = '0;
            w_sum_nxt    = '0;
            w_count_nxt  = '0;
            w_parity_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        w_acc_nxt   = SEED ^ in_data;
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = in_last ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_xfer) begin
                        w_acc_nxt   = r_acc ^ in_data;
                        w_cnt_nxt   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
                        w_state_nxt = in_last ? HOLD : ACCUM;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        w_state_nxt  = IDLE;
                        w_acc_nxt    = SEED;
                        w_cnt_nxt    = '0;
                        w_sum_nxt    = '0;
                        w_count_nxt  = '0;
                        w_parity_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase

            // Snapshot the updated accumulator on the edge that enters HOLD
            if (r_state != HOLD && w_state_nxt == HOLD) begin
                w_sum_nxt    = w_acc_nxt;
                w_count_nxt  = w_cnt_nxt;
                w_parity_nxt = ^w_acc_nxt;
            end
        end

        w_valid_nxt = (w_state_nxt == HOLD);
        w_ready_nxt = (w_state_nxt != HOLD);
    end

    assign in_ready   = r_ready;
    assign out_valid  = r_valid;
    assign out_sum    = r_sum;
    assign out_count  = r_count;
    assign out_parity = r_parity;

endmodule
